// File: rtl/phase_seq_pkg.sv
// Shared sizing helpers, FSM state codes and fail-cause encoding for the
// column-block phase sequencer.
package phase_seq_pkg;

  function automatic int blocks_of(input int k, input int n);
    return k / n;
  endfunction

  function automatic int cw_of(input int k, input int n);
    return $clog2(k / n + 1);
  endfunction

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LAUNCH   = 2'd1;
  localparam logic [1:0] ST_WAIT     = 2'd2;
  localparam logic [1:0] ST_CHECKERR = 2'd3;

  // Reserved for a later status register that records why the last fail fired.
  typedef enum logic [1:0] {
    FC_NONE  = 2'd0,
    FC_RANGE = 2'd1,
    FC_PIVOT = 2'd2
  } fail_cause_e;

endpackage

// File: rtl/phase_seq_if.sv
// Control and step-engine signal bundle for phase_seq.
interface phase_seq_if #(
  parameter int CW = phase_seq_pkg::cw_of(16, 4)
);
  // Pulse handshakes: start is a one-cycle request taken only when idle;
  // step_start launches one step and the engine answers with a one-cycle
  // step_done (step_fail meaningful only alongside it); done/fail end a phase.
  logic          start;
  logic [CW-1:0] start_block;
  logic [CW-1:0] end_block;
  logic          abort;
  logic          busy;
  logic          done;
  logic          fail;
  logic [CW-1:0] fail_block;
  logic [CW-1:0] steps_done;
  logic          step_start;
  logic [CW-1:0] step_col_block;
  logic          step_first;
  logic          step_done;
  logic          step_fail;

  modport slave (
    input  start, start_block, end_block, abort, step_done, step_fail,
    output busy, done, fail, fail_block, steps_done,
           step_start, step_col_block, step_first
  );

  modport master (
    output start, start_block, end_block, abort, step_done, step_fail,
    input  busy, done, fail, fail_block, steps_done,
           step_start, step_col_block, step_first
  );

endinterface

// File: rtl/phase_seq.sv
// Column-block sequencer: launches the step engine once per block over a
// programmable range and reports completion, step failure or an illegal range.
module phase_seq
  import phase_seq_pkg::*;
#(
  parameter int N = 4,
  parameter int K = 16,
  parameter int L = 8
) (
  input  logic       clk,
  input  logic       rst,
  phase_seq_if.slave bus,
  output logic [1:0] o_dbg_state
);

  localparam int BLOCKS = blocks_of(K, N);
  localparam int CW     = cw_of(K, N);

  if ((K % N) != 0 || N < 1 || L < 1) begin : g_param_check
    $error("phase_seq: K must be a non-zero multiple of N and L positive");
  end

  logic [1:0]    r_state;
  logic [CW-1:0] r_col;
  logic [CW-1:0] r_end;
  logic [CW-1:0] r_fail_block;
  logic [CW-1:0] r_steps;
  logic          r_done;
  logic          r_fail;
  logic          r_first;
  logic          w_bad_range;
  logic          w_last;

  assign w_bad_range = (bus.start_block > bus.end_block) ||
                       (bus.end_block >= CW'(BLOCKS));
  assign w_last      = (r_col == r_end);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_col        <= '0;
      r_end        <= '0;
      r_fail_block <= '0;
      r_steps      <= '0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_first      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_fail <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // abort in the same cycle drops the request
          if (bus.start && !bus.abort) begin
            r_col   <= bus.start_block;
            r_end   <= bus.end_block;
            r_steps <= '0;
            if (w_bad_range) begin
              r_state      <= ST_CHECKERR;
              r_fail       <= 1'b1;
              r_fail_block <= bus.start_block;
            end else begin
              r_state <= ST_LAUNCH;
              r_first <= 1'b1;
            end
          end
        end
        ST_LAUNCH: begin
          if (bus.abort) begin
            r_state <= ST_IDLE;
            r_first <= 1'b0;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.abort) begin
            r_state <= ST_IDLE;
            r_first <= 1'b0;
          end else if (bus.step_done) begin
            r_first <= 1'b0;
            if (bus.step_fail) begin
              r_state      <= ST_IDLE;
              r_fail       <= 1'b1;
              r_fail_block <= r_col;
            end else begin
              r_steps <= r_steps + CW'(1);
              if (w_last) begin
                r_state <= ST_IDLE;
                r_done  <= 1'b1;
              end else begin
                r_col   <= r_col + CW'(1);
                r_state <= ST_LAUNCH;
              end
            end
          end
        end
        ST_CHECKERR: r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  // An abort arriving during LAUNCH withholds the launch pulse in that cycle.
  assign bus.step_start     = (r_state == ST_LAUNCH) && !bus.abort;
  assign bus.step_col_block = r_col;
  assign bus.step_first     = r_first;
  assign bus.busy           = (r_state == ST_LAUNCH) || (r_state == ST_WAIT);
  assign bus.done           = r_done;
  assign bus.fail           = r_fail;
  assign bus.fail_block     = r_fail_block;
  assign bus.steps_done     = r_steps;
  assign o_dbg_state        = r_state;

endmodule

// File: doc/phase_seq.md
Name: phase_seq

Overview:
- Generalised column-block sequencer for the single-pass GF(2) systemizer.
- Launches the external step engine once per column block over a programmable block range [start_block, end_block], using a start/done handshake.
- Adds behaviour the fixed-range phase controller lacks: step failure reporting (singular pivot), abort, range checking, progress count.
- Sits between the top-level key-generation controller and the step engine. It owns no memory; all matrix data ports bypass it.

Parameters:
- N, 4, column-block width in bits (columns processed per step)
- K, 16, total columns to systemize; K % N == 0 required
- L, 8, matrix rows; passed through for sizing only
- BLOCKS, K/N, derived localparam: number of column blocks
- CW, $clog2(K/N+1), derived localparam: block index / counter width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a phase; sampled only when idle
- start_block  in  CW  first block to process; sampled with start
- end_block  in  CW  last block to process, inclusive; sampled with start
- abort  in  1  stop sequencing at once; no done is produced
- busy  out  1  high from the cycle after an accepted start until return to IDLE
- done  out  1  one-cycle pulse: all blocks in range completed without failure
- fail  out  1  one-cycle pulse: step failure or illegal range
- fail_block  out  CW  block index tied to the last fail; holds until next fail
- steps_done  out  CW  steps completed in current/last phase; cleared on accepted start
- step_start  out  1  one-cycle launch pulse to the step engine
- step_col_block  out  CW  block index for the step; stable while a step runs
- step_first  out  1  high from step_start of the first step until its step_done (the functionA equivalent)
- step_done  in  1  one-cycle completion pulse from the step engine
- step_fail  in  1  qualifies step_done: pivot not found; ignored without step_done

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; fail_block=0; steps_done=0.
- States: IDLE, LAUNCH, WAIT, CHECKERR.
- IDLE:
  - start at cycle t: latch the range; clear steps_done.
  - If start_block > end_block or end_block >= BLOCKS: go to CHECKERR.
  - Otherwise go to LAUNCH with step_col_block=start_block.
- CHECKERR: at t+1, fail=1 and fail_block=start_block. No step_start. Return to IDLE.
- LAUNCH (one cycle): step_start=1, busy=1. step_start is first asserted at t+1 after the accepted start. Go to WAIT.
- WAIT:
  - Hold step_col_block.
  - On step_done without step_fail: steps_done++.
    - If step_col_block == end_block: done=1 next cycle; go to IDLE.
    - Otherwise step_col_block+1 and go to LAUNCH. The next step_start is asserted the cycle after step_done, so there is a 1-cycle gap.
  - On step_done with step_fail: fail=1 next cycle, fail_block=step_col_block, steps_done not incremented; go to IDLE.
- step_first: set with the first step_start of a phase; cleared on that step's step_done.
- abort in any non-IDLE state:
  - IDLE next cycle; busy=0; step_first=0.
  - Any pending step_start is suppressed; no done or fail.
  - abort takes priority over a simultaneous step_done.
- start while not IDLE: ignored. start and abort in the same cycle in IDLE: abort wins, start is dropped.
- step_done in IDLE or LAUNCH: ignored (protocol error; the bench flags it).
- done and fail are never asserted in the same cycle; busy falls in the same cycle done or fail is asserted.
- Single-block range (start_block == end_block) is legal: exactly one step.
- All counters are CW wide, with no wrap possible since end_block < BLOCKS.

Decomposition:
- Package phase_seq_pkg: CW/BLOCKS computation helpers, state enum (IDLE, LAUNCH, WAIT, CHECKERR), fail-cause encoding for future status register use.
- Single flat module; no sub-module needed. Existing step is instantiated by the parent, not here.

Test Plan:
- N=4, K=16; start with start_block=0, end_block=3; step engine model returns step_done 5 cycles after each step_start -> four step_start pulses with col_block 0,1,2,3; step_first high only during the first step; done 1 cycle after 4th step_done; steps_done=4.
- start_block=2, end_block=2 -> exactly one step_start with col_block=2; done follows; steps_done=1.
- Range 0..3, step_fail asserted with step_done of block 1 -> fail pulse, fail_block=1, steps_done=1, no further step_start, no done.
- start_block=3, end_block=1; then start_block=0, end_block=4 -> each: fail at t+1, fail_block=start_block (3, then 0), zero step_start, busy never high.
- abort asserted in the same cycle as step_done of block 2 -> IDLE, no step_start for block 3, no done or fail. A start issued during busy is ignored; the next start after IDLE runs normally.
- Assert rst=0 asynchronously mid-WAIT -> all outputs 0 immediately; after release, a fresh start runs a full 0..3 phase correctly.
